// File: rtl/auth_pkg.sv
// Shared types and default sizing for the code-entry sequencer and its retry counter.
package auth_pkg;

    typedef enum logic [2:0] {
        ST_UNSET   = 3'd0,
        ST_ARMED   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_RESULT  = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_MAX_TRIES   = 3;
    localparam int DEFAULT_LOCK_CYCLES = 16;

endpackage

// File: rtl/auth_retry_counter.sv
// Retry budget and lockout timer: tries_left restore/decrement and the lockout down-counter.
module auth_retry_counter
    import auth_pkg::*;
#(
    parameter int MAX_TRIES   = DEFAULT_MAX_TRIES,
    parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES,
    parameter int TW          = $clog2(MAX_TRIES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          restore,
    input  logic          decrement,
    input  logic          start_lock,
    input  logic          lock_active,
    output logic [TW-1:0] tries_left,
    output logic          lock_expire
);

    localparam int CW = $clog2(LOCK_CYCLES + 1);

    logic [CW-1:0] lock_cnt;

    // Remaining wrong guesses: restored on load/match/expiry, zeroed when lockout starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tries_left <= '0;
        end else if (restore) begin
            tries_left <= TW'(MAX_TRIES);
        end else if (start_lock) begin
            tries_left <= '0;
        end else if (decrement) begin
            tries_left <= tries_left - TW'(1);
        end
    end

    // Lockout timer: loaded with LOCK_CYCLES-1 so the locked state lasts exactly LOCK_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (start_lock) begin
            lock_cnt <= CW'(LOCK_CYCLES - 1);
        end else if (lock_active && (lock_cnt != '0)) begin
            lock_cnt <= lock_cnt - CW'(1);
        end
    end

    assign lock_expire = lock_active && (lock_cnt == '0);

endmodule

// File: rtl/code_entry_sequencer.sv
// Serial front end for the bit-level auth comparator: stores a setter code, streams
// setter/guesser bit pairs LSB first, folds per-bit matches into a verdict, and
// enforces a retry budget with a timed lockout.
//
// state   | meaning
// UNSET   | no code loaded, guesses refused
// ARMED   | code loaded, waiting for a guess or a code reload
// COMPARE | streaming bit pairs, accumulating the match
// RESULT  | one-cycle verdict, retry budget update
// LOCKED  | retry budget exhausted, all requests ignored
module code_entry_sequencer
    import auth_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int MAX_TRIES   = DEFAULT_MAX_TRIES,
    parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             set_valid,
    input  logic [WIDTH-1:0]                 set_code,
    input  logic                             guess_valid,
    input  logic [WIDTH-1:0]                 guess_code,
    output logic                             guess_ready,
    output logic                             setter_bit,
    output logic                             guesser_bit,
    input  logic                             bit_match,
    output logic                             done,
    output logic                             matched,
    output logic                             unmatched,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_next;
    logic [WIDTH-1:0] code, guess;
    logic [IW-1:0]    idx;
    logic             acc;
    logic             last_bit, cmp_bit;
    logic             load_code, accept_guess;
    logic             restore, decrement, start_lock, lock_expire;

    assign last_bit     = (idx == IW'(WIDTH - 1));
    assign cmp_bit      = acc & bit_match;
    assign load_code    = set_valid && ((state == ST_UNSET) || (state == ST_ARMED));
    assign accept_guess = (state == ST_ARMED) && guess_valid && !set_valid;
    assign restore      = load_code || ((state == ST_RESULT) && matched) || lock_expire;
    assign decrement    = (state == ST_RESULT) && !matched && (tries_left > TW'(1));
    assign start_lock   = (state == ST_RESULT) && !matched && (tries_left <= TW'(1));

    // Next-state decode plus the combinational outputs (ready and comparator bits).
    always_comb begin
        state_next  = state;
        guess_ready = 1'b0;
        setter_bit  = 1'b0;
        guesser_bit = 1'b0;
        case (state)
            ST_UNSET: begin
                if (set_valid) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                guess_ready = 1'b1;
                if (accept_guess) state_next = ST_COMPARE;
            end
            ST_COMPARE: begin
                setter_bit  = code[idx];
                guesser_bit = guess[idx];
                if (last_bit) state_next = ST_RESULT;
            end
            ST_RESULT: begin
                state_next = start_lock ? ST_LOCKED : ST_ARMED;
            end
            ST_LOCKED: begin
                if (lock_expire) state_next = ST_ARMED;
            end
            default: state_next = ST_UNSET;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_UNSET;
        else        state <= state_next;
    end

    // Code/guess storage, bit index, match accumulator and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code      <= '0;
            guess     <= '0;
            idx       <= '0;
            acc       <= 1'b0;
            matched   <= 1'b0;
            unmatched <= 1'b0;
            done      <= 1'b0;
            locked    <= 1'b0;
        end else begin
            if (load_code) code <= set_code;
            if (accept_guess) begin
                guess     <= guess_code;
                idx       <= '0;
                acc       <= 1'b1;
                matched   <= 1'b0;
                unmatched <= 1'b0;
            end else if (state == ST_COMPARE) begin
                acc <= cmp_bit;
                if (last_bit) begin
                    idx       <= '0;
                    matched   <= cmp_bit;
                    unmatched <= !cmp_bit;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
            done   <= (state_next == ST_RESULT);
            locked <= (state_next == ST_LOCKED);
        end
    end

    auth_retry_counter #(
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .TW          (TW)
    ) u_retry (
        .clk         (clk),
        .rst_n       (rst_n),
        .restore     (restore),
        .decrement   (decrement),
        .start_lock  (start_lock),
        .lock_active (state == ST_LOCKED),
        .tries_left  (tries_left),
        .lock_expire (lock_expire)
    );

endmodule

// File: doc/code_entry_sequencer.md
# code_entry_sequencer

Serial front end for the bit-level auth comparator. The block stores an 8-bit setter code and accepts 8-bit guesses. For each guess it streams the setter/guesser bit pairs into the comparator, one pair per cycle, and folds the comparator's per-bit match back into a whole-code verdict. It enforces a retry budget with a timed lockout, and sits directly upstream of the comparator, which it also consumes.

## Interface
- `WIDTH`, 8, code width in bits; also the number of compare cycles.
- `MAX_TRIES`, 3, consecutive wrong guesses allowed before lockout (≥1).
- `LOCK_CYCLES`, 16, lockout duration in clock cycles (≥1).

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `set_valid`  in  1  load request for a new setter code.
- `set_code`  in  WIDTH  setter code; sampled when `set_valid` is accepted.
- `guess_valid`  in  1  guess request.
- `guess_code`  in  WIDTH  guess; sampled on acceptance.
- `guess_ready`  out  1  guess can be accepted this cycle.
- `setter_bit`  out  1  to comparator `setter_var`.
- `guesser_bit`  out  1  to comparator `guesser_var`.
- `bit_match`  in  1  comparator per-bit result (XNOR), combinational, same cycle.
- `done`  out  1  one-cycle pulse: verdict ready.
- `matched`  out  1  last verdict was a full match.
- `unmatched`  out  1  last verdict was a mismatch.
- `locked`  out  1  lockout active.
- `tries_left`  out  $clog2(MAX_TRIES+1)  remaining wrong guesses before lockout.

## Operation
States: UNSET, ARMED, COMPARE, RESULT, LOCKED.

- **UNSET**
  - Entered on reset; `guess_ready`=0.
  - `set_valid` loads `set_code`, sets `tries_left`=MAX_TRIES, moves to ARMED.
- **ARMED**
  - `guess_ready`=1.
  - `guess_valid` latches `guess_code`, sets bit index=0 and acc=1, clears `matched`/`unmatched` to 0, moves to COMPARE.
  - `set_valid` reloads the code and restores `tries_left`=MAX_TRIES.
  - Simultaneous `set_valid`+`guess_valid`: set wins; the guess is not accepted.
- **COMPARE**
  - Drives `setter_bit`=code[idx] and `guesser_bit`=guess[idx], LSB first.
  - acc &= `bit_match` each cycle.
  - At idx=WIDTH-1: registers `matched`=acc and `unmatched`=!acc, moves to RESULT.
  - Ignores `set_valid`.
- **RESULT**
  - One cycle; `done`=1.
  - On match: `tries_left`=MAX_TRIES, then ARMED.
  - On mismatch with `tries_left`>1: decrement, then ARMED.
  - On mismatch with `tries_left`==1: set `tries_left`=0, load the lock counter with LOCK_CYCLES-1, then LOCKED.
- **LOCKED**
  - `locked`=1, `guess_ready`=0; `set_valid` and `guess_valid` are ignored.
  - Counter decrements to 0, then `tries_left`=MAX_TRIES and the state moves to ARMED.
- **Outside COMPARE:** `setter_bit`=`guesser_bit`=0.
- **Verdict hold:** `matched`/`unmatched` keep their value until the next guess is accepted. Both read 0 before the first verdict.
- **Reset** (any state, including mid-COMPARE or mid-LOCKED):
  - State returns to UNSET.
  - Code, guess, acc, idx and counters clear.
  - All outputs go to 0, including `tries_left`.

## Timing
- Guess accepted at edge E0. Bit k is presented during the cycle after edge E(k), for k=0..WIDTH-1.
- Verdict registers at E(WIDTH). `done` is high in the following cycle. `guess_ready` returns after E(WIDTH+1).
- Throughput: one guess per WIDTH+2 cycles.
- Lockout: `locked` is high for exactly LOCK_CYCLES cycles. `guess_ready` rises in the next cycle.
- Outputs are registered, except `setter_bit`/`guesser_bit` (decoded from registered state/idx/code) and `guess_ready` (decoded from state).
- Comparator path `setter_bit`/`guesser_bit` → `bit_match` → acc is one combinational hop inside a single cycle.

## Structure
- Shared package `auth_pkg`:
  - state enum.
  - default `WIDTH`, `MAX_TRIES`, `LOCK_CYCLES`.
- One natural sub-module: `auth_retry_counter`. It holds the `tries_left` decrement/restore logic and the lockout down-counter, and reports `lock_expire`.
- The FSM and the shift/index datapath stay in the top.

## Test plan
- Reset, then load set_code=8'hA5, guess 8'hA5 → bits 1,0,1,0,0,1,0,1 presented over 8 cycles; `done` at cycle 9; `matched`=1, `unmatched`=0; `tries_left`=3.
- set_code=8'hA5, guess 8'h25 (MSB differs) → `unmatched`=1 after 8 compare cycles; `tries_left`=2.
- Three consecutive wrong guesses → `locked`=1 for 16 cycles with `tries_left`=0; a guess inside the window is ignored; afterwards `tries_left`=3 and a correct guess gives `matched`=1.
- `set_valid` with 8'h3C and `guess_valid` in the same ARMED cycle → code reloads, no compare starts, `guess_ready` stays 1; a following guess 8'h3C matches.
- `rst_n`=0 at compare bit 4 → next cycle: UNSET, all outputs 0, and `guess_ready`=0 until a new code is set.
